control_encoder: RTL and testbench
==================================

Name: control_encoder

Overview:
- Inverse of the opcode-to-control decoder: accepts a 12-bit decoded control bundle and recovers the 6-bit opcode that produces it.
- Results are buffered in a small FIFO with valid/ready handshakes on both sides.
- Use: trace/debug and self-check of the control path. The datapath control bundle is re-encoded and compared against the fetched opcode downstream.
- Bundles outside the legal set are flagged illegal.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  bundle present
- in_ready  out  1  encoder can accept a bundle
- Jump, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, BranchNE, BranchEQ  in  1 each  control bundle bits
- ALUOp  in  3  ALU operation field
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_op  out  6  recovered opcode
- out_illegal  out  1  bundle not in the legal table

Behaviour:
- Bundle packing, MSB to LSB: {Jump, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, BranchNE, BranchEQ, ALUOp}.
- Legal table (packed bundle -> opcode):
  - 0_1_001_00_00_111 -> 0x00 (R-type)
  - 0_0_101_00_00_100 -> 0x08 (ADDI)
  - 0_0_101_00_00_101 -> 0x0D (ORI)
  - 0_0_101_00_00_110 -> 0x0C (ANDI)
  - 0_0_101_00_00_000 -> 0x0F (LUI)
  - 0_0_111_10_00_100 -> 0x23 (LW)
  - 0_0_100_01_00_100 -> 0x2B (SW)
  - 0_0_0x0_00_01_001 -> 0x04 (BEQ)
  - 0_0_0x0_00_10_001 -> 0x05 (BNE)
  - 1_0_000_00_00_000 -> 0x02 (J)
  - 1_0_001_00_00_000 -> 0x03 (JAL)
- Don't-care bit: for BEQ and BNE, MemtoReg is ignored; both values match.
- Any other bundle, including all-zero: out_op = 0x3F, out_illegal = 1. Legal bundles give out_illegal = 0.
- Push condition: in_valid && in_ready. The encoded {op, illegal} is written into the FIFO tail on that clk edge.
- Pop condition: out_valid && out_ready. The head advances on that clk edge.
- Latency: 1 cycle. A bundle pushed at edge N gives out_valid = 1 after edge N when the FIFO was empty. There is no combinational bypass.
- in_ready = (count != DEPTH). It depends only on registered state, not on out_ready.
- Full: a push is not possible. A pop in the same cycle frees a slot, and in_ready rises after that edge.
- Empty: out_valid = 0, and out_op/out_illegal hold their last value (don't-care).
- Simultaneous push and pop when neither full nor empty: count is unchanged and the pointers wrap modulo DEPTH.
- Stall: while out_valid && !out_ready, out_op and out_illegal stay stable.
- count has width clog2(DEPTH)+1. Read and write pointers have width clog2(DEPTH) and wrap naturally.
- Reset (asynchronous, any time, including mid-transfer): pointers and count go to 0, in_ready = 1, out_valid = 0, out_op = 0x00, out_illegal = 0. All buffered entries are discarded.
- Outputs are driven from registers or FIFO storage only.

Optional Feature:
- Macro: CONTROL_ENCODER_STATS_EN.
- Defined:
  - Adds outputs cnt_total [CNT_W-1:0] and cnt_illegal [CNT_W-1:0].
  - cnt_total increments on every push.
  - cnt_illegal increments on every push whose bundle is illegal.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Push each of the 11 legal bundles back-to-back with out_ready = 1 -> out_op sequence 0x00, 0x08, 0x0D, 0x0C, 0x0F, 0x23, 0x2B, 0x04, 0x05, 0x02, 0x03, each 1 cycle after its push, out_illegal = 0 throughout.
- BEQ bundle with MemtoReg = 1, then all-zero bundle, then 0_1_001_00_00_000 -> out_op 0x04/illegal 0, then 0x3F/illegal 1, then 0x3F/illegal 1.
- out_ready = 0, push 5 bundles at DEPTH = 4 -> in_ready low after the 4th push, 5th held off. Raise out_ready for one cycle -> in_ready returns high after that edge, 5th accepted, order preserved.
- Continuous push and pop with random out_ready for 1000 cycles -> scoreboard order and values match, no loss or duplication, count never exceeds DEPTH.
- Assert reset with 3 entries buffered and out_ready = 0 -> out_valid = 0 and in_ready = 1 immediately, without waiting for clk; subsequent push yields only the new entry.
- With CONTROL_ENCODER_STATS_EN, CNT_W = 2: push 5 illegal bundles -> cnt_total = 3 and cnt_illegal = 3 (saturated); reset clears both to 0.

Source files
------------

// File: rtl/control_encoder.sv
// control_encoder: re-encodes a decoded 12-bit control bundle into its 6-bit
// opcode and buffers {op, illegal} in a DEPTH-entry valid/ready FIFO.
// Ports: clk, reset (async, active high); in_valid/in_ready plus the bundle
// bits Jump..BranchEQ and ALUOp[2:0] on the input side; out_valid/out_ready,
// out_op[5:0], out_illegal on the output side.
// Optional macro CONTROL_ENCODER_STATS_EN adds cnt_total/cnt_illegal
// saturating push counters of width CNT_W.
module control_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Jump,
  input  logic             RegDst,
  input  logic             ALUSrc,
  input  logic             MemtoReg,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             BranchNE,
  input  logic             BranchEQ,
  input  logic [2:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_op,
  output logic             out_illegal
`ifdef CONTROL_ENCODER_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_illegal
`endif
);

`ifdef CONTROL_ENCODER_STATS_EN
  localparam int AW = $clog2(DEPTH);
`else
  // CNT_W only sizes the counters; keep it referenced when they are absent
  localparam int AW = $clog2(DEPTH) + 0 * CNT_W;
`endif

  logic [11:0]   w_bundle;
  logic [5:0]    w_op;
  logic          w_illegal;
  logic          w_push;
  logic          w_pop;

  logic [6:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  assign w_bundle = {Jump, RegDst, ALUSrc, MemtoReg, RegWrite,
                     MemRead, MemWrite, BranchNE, BranchEQ, ALUOp};

  always_comb begin
    w_op      = 6'h3F;
    w_illegal = 1'b1;
    unique casez (w_bundle)
      12'b0_1_001_00_00_111: begin
        w_op      = 6'h00;
        w_illegal = 1'b0;
      end
      12'b0_0_101_00_00_100: begin
        w_op      = 6'h08;
        w_illegal = 1'b0;
      end
      12'b0_0_101_00_00_101: begin
        w_op      = 6'h0D;
        w_illegal = 1'b0;
      end
      12'b0_0_101_00_00_110: begin
        w_op      = 6'h0C;
        w_illegal = 1'b0;
      end
      12'b0_0_101_00_00_000: begin
        w_op      = 6'h0F;
        w_illegal = 1'b0;
      end
      12'b0_0_111_10_00_100: begin
        w_op      = 6'h23;
        w_illegal = 1'b0;
      end
      12'b0_0_100_01_00_100: begin
        w_op      = 6'h2B;
        w_illegal = 1'b0;
      end
      // branches leave MemtoReg unused, so either value matches
      12'b0_0_0?0_00_01_001: begin
        w_op      = 6'h04;
        w_illegal = 1'b0;
      end
      12'b0_0_0?0_00_10_001: begin
        w_op      = 6'h05;
        w_illegal = 1'b0;
      end
      12'b1_0_000_00_00_000: begin
        w_op      = 6'h02;
        w_illegal = 1'b0;
      end
      12'b1_0_001_00_00_000: begin
        w_op      = 6'h03;
        w_illegal = 1'b0;
      end
      default: begin
        w_op      = 6'h3F;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign in_ready  = (r_count != (AW+1)'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // storage is cleared on reset so the head reads 0x00 / legal afterwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_op, w_illegal};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  assign out_op      = r_mem[r_rd_ptr][6:1];
  assign out_illegal = r_mem[r_rd_ptr][0];

`ifdef CONTROL_ENCODER_STATS_EN
  logic [CNT_W-1:0] r_cnt_total;
  logic [CNT_W-1:0] r_cnt_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_total   <= '0;
      r_cnt_illegal <= '0;
    end else if (w_push) begin
      if (r_cnt_total != '1) begin
        r_cnt_total <= r_cnt_total + CNT_W'(1);
      end
      if (w_illegal && (r_cnt_illegal != '1)) begin
        r_cnt_illegal <= r_cnt_illegal + CNT_W'(1);
      end
    end
  end

  assign cnt_total   = r_cnt_total;
  assign cnt_illegal = r_cnt_illegal;
`endif

endmodule

// File: tb/tb_control_encoder.sv
// tb_control_encoder: vector table, directed FIFO corner cases and a
// randomized run against a table-lookup reference model with a queue.
module tb_control_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       Jump, RegDst, ALUSrc, MemtoReg, RegWrite;
  logic       MemRead, MemWrite, BranchNE, BranchEQ;
  logic [2:0] ALUOp;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_op;
  logic       out_illegal;
`ifdef CONTROL_ENCODER_STATS_EN
  logic [CNT_W-1:0] cnt_total;
  logic [CNT_W-1:0] cnt_illegal;
`endif

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  control_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Jump(Jump),
    .RegDst(RegDst),
    .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg),
    .RegWrite(RegWrite),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .BranchNE(BranchNE),
    .BranchEQ(BranchEQ),
    .ALUOp(ALUOp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_op(out_op),
    .out_illegal(out_illegal)
`ifdef CONTROL_ENCODER_STATS_EN
    ,
    .cnt_total(cnt_total),
    .cnt_illegal(cnt_illegal)
`endif
  );

  // reference: legal patterns with a care-mask (MemtoReg is bit 8)
  logic [11:0] ref_pat [11] = '{
    12'b0_1_001_00_00_111, 12'b0_0_101_00_00_100, 12'b0_0_101_00_00_101,
    12'b0_0_101_00_00_110, 12'b0_0_101_00_00_000, 12'b0_0_111_10_00_100,
    12'b0_0_100_01_00_100, 12'b0_0_000_00_01_001, 12'b0_0_000_00_10_001,
    12'b1_0_000_00_00_000, 12'b1_0_001_00_00_000};
  logic [11:0] ref_mask [11] = '{
    12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
    12'hFFF, 12'hEFF, 12'hEFF, 12'hFFF, 12'hFFF};
  logic [5:0] ref_op [11] = '{
    6'h00, 6'h08, 6'h0D, 6'h0C, 6'h0F, 6'h23,
    6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

  function automatic logic [6:0] model_enc(input logic [11:0] b);
    for (int i = 0; i < 11; i++) begin
      if ((b & ref_mask[i]) == (ref_pat[i] & ref_mask[i])) begin
        return {ref_op[i], 1'b0};
      end
    end
    return {6'h3F, 1'b1};
  endfunction

  typedef struct {
    logic [11:0] b;
    logic [5:0]  op;
    logic        ill;
  } vec_t;

  vec_t vecs [14];
  logic [6:0] q [$];

  task automatic drive(input logic [11:0] b);
    {Jump, RegDst, ALUSrc, MemtoReg, RegWrite,
     MemRead, MemWrite, BranchNE, BranchEQ, ALUOp} = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    vecs[0]  = '{12'b0_1_001_00_00_111, 6'h00, 1'b0};
    vecs[1]  = '{12'b0_0_101_00_00_100, 6'h08, 1'b0};
    vecs[2]  = '{12'b0_0_101_00_00_101, 6'h0D, 1'b0};
    vecs[3]  = '{12'b0_0_101_00_00_110, 6'h0C, 1'b0};
    vecs[4]  = '{12'b0_0_101_00_00_000, 6'h0F, 1'b0};
    vecs[5]  = '{12'b0_0_111_10_00_100, 6'h23, 1'b0};
    vecs[6]  = '{12'b0_0_100_01_00_100, 6'h2B, 1'b0};
    vecs[7]  = '{12'b0_0_000_00_01_001, 6'h04, 1'b0};
    vecs[8]  = '{12'b0_0_000_00_10_001, 6'h05, 1'b0};
    vecs[9]  = '{12'b1_0_000_00_00_000, 6'h02, 1'b0};
    vecs[10] = '{12'b1_0_001_00_00_000, 6'h03, 1'b0};
    vecs[11] = '{12'b0_0_010_00_01_001, 6'h04, 1'b0};
    vecs[12] = '{12'b0_0_000_00_00_000, 6'h3F, 1'b1};
    vecs[13] = '{12'b0_1_001_00_00_000, 6'h3F, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(12'h000);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_illegal", out_illegal, 0);

    // table: back-to-back pushes with a free-running consumer
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].b);
      in_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_op", i), out_op, vecs[i].op);
      chk($sformatf("vec%0d_ill", i), out_illegal, vecs[i].ill);
    end
    in_valid = 1'b0;
    tick();
    chk("vec_drained", out_valid, 0);

    // full FIFO, held-off fifth push, single-cycle pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill%0d_ready", i), in_ready, 1);
      drive(vecs[i].b);
      in_valid = 1'b1;
      tick();
    end
    chk("full_ready", in_ready, 0);
    drive(vecs[4].b);
    tick();
    tick();
    chk("full_hold_ready", in_ready, 0);
    chk("stall_op", out_op, vecs[0].op);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_pop_ready", in_ready, 1);
    chk("after_pop_op", out_op, vecs[1].op);
    tick();
    in_valid = 1'b0;
    chk("refull_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("drain%0d_valid", i), out_valid, 1);
      chk($sformatf("drain%0d_op", i), out_op, vecs[i].op);
      tick();
    end
    chk("drain_empty", out_valid, 0);

    // randomized traffic against the queue model
    q = {};
    for (int c = 0; c < 1000 + DEPTH + 2; c++) begin
      logic [11:0] b;
      logic        push, pop;
      chk("rnd_valid", out_valid, q.size() != 0);
      chk("rnd_ready", in_ready, q.size() != DEPTH);
      if (q.size() != 0) begin
        chk("rnd_op", out_op, q[0][6:1]);
        chk("rnd_ill", out_illegal, q[0][0]);
      end
      if ($urandom_range(0, 1) == 1) begin
        b = ref_pat[$urandom_range(0, 10)];
        if (b[3] || b[4]) b[8] = 1'($urandom_range(0, 1));
      end else begin
        b = 12'($urandom);
      end
      drive(b);
      in_valid  = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
      push = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() > 0);
      tick();
      if (pop) void'(q.pop_front());
      if (push) q.push_back(model_enc(b));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // asynchronous reset with three entries buffered
    for (int i = 5; i < 8; i++) begin
      drive(vecs[i].b);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 1);
    chk("async_rst_op", out_op, 0);
    tick();
    reset = 1'b0;
    drive(vecs[8].b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_op", out_op, vecs[8].op);
    out_ready = 1'b1;
    tick();
    chk("post_rst_empty", out_valid, 0);

`ifdef CONTROL_ENCODER_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("cnt_tot_rst", cnt_total, 0);
    drive(12'h000);
    in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    chk("cnt_tot_sat", cnt_total, 3);
    chk("cnt_ill_sat", cnt_illegal, 3);
    reset = 1'b1;
    #1;
    chk("cnt_tot_clr", cnt_total, 0);
    chk("cnt_ill_clr", cnt_illegal, 0);
    tick();
    reset = 1'b0;
    drive(vecs[1].b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("cnt_tot_legal", cnt_total, 1);
    chk("cnt_ill_legal", cnt_illegal, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
